// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_multi
//  Purpose  : N-channel PWM generator with a shared prescaler/period counter,
//             shadowed duty registers and edge/center-aligned counting.
//             Define PWM_PHASE_STAGGER_EN to phase-offset channels in edge mode.
//  Revision : 1.0  initial release
// ============================================================================
module pwm_multi #(
    parameter int                N_CH       = 4,
    parameter int                PERIOD     = 100,
    parameter int                PRESCALE   = 2,
    parameter int                RESET_DUTY = 50,
    parameter logic [N_CH-1:0]   POLARITY   = '0,
    localparam int               CW         = $clog2(PERIOD + 1),
    localparam int               WW         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 center,
    input  logic [N_CH-1:0]      oe_in,
    input  logic                 wr_en,
    input  logic [WW-1:0]        wr_ch,
    input  logic [CW-1:0]        wr_duty,
    output logic [N_CH-1:0]      pwm_out,
    output logic [N_CH-1:0]      pwm_oe,
    output logic                 period_start
);

    localparam int               PRW          = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0]    c_period     = CW'(PERIOD);
    localparam logic [CW-1:0]    c_period_m1  = CW'(PERIOD - 1);
    localparam logic [CW-1:0]    c_reset_duty = CW'(RESET_DUTY);
    localparam logic [PRW-1:0]   c_pre_max    = PRW'(PRESCALE - 1);
    localparam logic [WW:0]      c_n_ch       = (WW + 1)'(N_CH);
    localparam logic [0:0]       c_dir_up     = 1'b0;
    localparam logic [0:0]       c_dir_dn     = 1'b1;
    localparam logic [0:0]       c_mode_edge  = 1'b0;

    logic [PRW-1:0]              pre_q, pre_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [0:0]                  dir_q, dir_d;
    logic [0:0]                  mode_q, mode_d;
    logic                        run_prev_q, run_prev_d;
    logic [N_CH-1:0][CW-1:0]     shadow_q, shadow_d;
    logic [N_CH-1:0][CW-1:0]     active_q, active_d;
    logic [N_CH-1:0]             pwm_out_q, pwm_out_d;
    logic [N_CH-1:0]             pwm_oe_q, pwm_oe_d;
    logic                        period_start_q, period_start_d;

    logic                        w_tick;
    logic                        w_pse;
    logic [CW-1:0]               w_cnt_nxt;
    logic [0:0]                  w_dir_nxt;
    logic [N_CH-1:0]             w_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q          <= c_pre_max;
            cnt_q          <= '0;
            dir_q          <= c_dir_up;
            mode_q         <= c_mode_edge;
            run_prev_q     <= 1'b0;
            shadow_q       <= {N_CH{c_reset_duty}};
            active_q       <= {N_CH{c_reset_duty}};
            pwm_out_q      <= POLARITY;
            pwm_oe_q       <= '0;
            period_start_q <= 1'b0;
        end else begin
            pre_q          <= pre_d;
            cnt_q          <= cnt_d;
            dir_q          <= dir_d;
            mode_q         <= mode_d;
            run_prev_q     <= run_prev_d;
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            pwm_out_q      <= pwm_out_d;
            pwm_oe_q       <= pwm_oe_d;
            period_start_q <= period_start_d;
        end
    end

    // Next counter value if a tick occurs; center mode bounces between 0 and PERIOD-1.
    always_comb begin
        w_cnt_nxt = cnt_q;
        w_dir_nxt = dir_q;
        if (mode_q == c_mode_edge) begin
            w_cnt_nxt = (cnt_q == c_period_m1) ? '0 : cnt_q + 1'b1;
            w_dir_nxt = c_dir_up;
        end else if (cnt_q == '0) begin
            w_cnt_nxt = CW'(1);
            w_dir_nxt = c_dir_up;
        end else if (dir_q == c_dir_up) begin
            if (cnt_q == c_period_m1) begin
                w_cnt_nxt = cnt_q - 1'b1;
                w_dir_nxt = c_dir_dn;
            end else begin
                w_cnt_nxt = cnt_q + 1'b1;
            end
        end else begin
            w_cnt_nxt = cnt_q - 1'b1;
        end
    end

    always_comb begin
        pre_d      = pre_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        mode_d     = mode_q;
        active_d   = active_q;
        shadow_d   = shadow_q;
        run_prev_d = run;
        w_tick     = 1'b0;
        w_pse      = 1'b0;

        if (wr_en && ({1'b0, wr_ch} < c_n_ch)) begin
            shadow_d[wr_ch] = (wr_duty > c_period) ? c_period : wr_duty;
        end

        if (!run) begin
            pre_d = c_pre_max;
            cnt_d = '0;
            dir_d = c_dir_up;
        end else begin
            w_tick = (pre_q == '0);
            pre_d  = w_tick ? c_pre_max : pre_q - 1'b1;
            if (w_tick) begin
                cnt_d = w_cnt_nxt;
                dir_d = w_dir_nxt;
            end
            w_pse = !run_prev_q || (w_tick && (w_cnt_nxt == '0));
            // Active takes the pre-write shadow so a coincident write waits a period.
            if (w_pse) begin
                active_d = shadow_q;
                mode_d   = center;
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CW-1:0] w_cnt_ch;
`ifdef PWM_PHASE_STAGGER_EN
        localparam logic [CW-1:0] c_off  = CW'(i * (PERIOD / N_CH));
        localparam logic [CW-1:0] c_wrap = CW'(PERIOD - i * (PERIOD / N_CH));
        always_comb begin
            w_cnt_ch = cnt_q;
            if (mode_q == c_mode_edge) begin
                w_cnt_ch = (cnt_q >= c_wrap) ? cnt_q - c_wrap : cnt_q + c_off;
            end
        end
`else
        assign w_cnt_ch = cnt_q;
`endif
        assign w_hit[i] = (w_cnt_ch < active_q[i]);
    end

    always_comb begin
        pwm_out_d      = run ? (w_hit ^ POLARITY) : POLARITY;
        pwm_oe_d       = oe_in;
        period_start_d = w_pse;
    end

    assign pwm_out      = pwm_out_q;
    assign pwm_oe       = pwm_oe_q;
    assign period_start = period_start_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_multi
//  Purpose  : Self-checking bench for pwm_multi (two instances: prescale 1 /
//             polarity 0, and prescale 2 / polarity 0101) against a period model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pwm_multi;

    localparam int P = 10;
    localparam int N = 4;
`ifdef PWM_PHASE_STAGGER_EN
    localparam int c_stride = P / N;
`else
    localparam int c_stride = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       center = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] oe_in = '0;
    logic [1:0] wr_ch = '0;
    logic [3:0] wr_duty = '0;
    logic [3:0] out_a, oe_a, out_b, oe_b;
    logic       ps_a, ps_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_multi #(.N_CH(4), .PERIOD(10), .PRESCALE(1), .RESET_DUTY(5), .POLARITY(4'b0000)) dut_a (
        .clk(clk), .rst(rst), .run(run), .center(center), .oe_in(oe_in),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
        .pwm_out(out_a), .pwm_oe(oe_a), .period_start(ps_a));

    pwm_multi #(.N_CH(4), .PERIOD(10), .PRESCALE(2), .RESET_DUTY(5), .POLARITY(4'b0101)) dut_b (
        .clk(clk), .rst(rst), .run(run), .center(center), .oe_in(oe_in),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
        .pwm_out(out_b), .pwm_oe(oe_b), .period_start(ps_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: position within the current period in ticks; count derived from it.
    int         m_presc[2] = '{1, 2};
    logic [3:0] m_pol[2]   = '{4'b0000, 4'b0101};
    bit         m_running[2];
    int         m_clks[2], m_pos[2];
    bit         m_mode[2];
    int         m_sh[2][4], m_act[2][4];
    logic [3:0] e_out[2], e_oe[2];
    logic       e_ps[2];

    function automatic int cnt_of(bit mode, int pos);
        return (!mode || pos < P) ? pos : 2 * (P - 1) - pos;
    endfunction

    function automatic int chan_cnt(bit mode, int c, int i);
        return mode ? c : (c + i * c_stride) % P;
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_running[k] = 0; m_clks[k] = 0; m_pos[k] = 0; m_mode[k] = 0;
                for (int i = 0; i < N; i++) begin m_sh[k][i] = 5; m_act[k][i] = 5; end
                e_out[k] = m_pol[k]; e_oe[k] = '0; e_ps[k] = 1'b0;
            end else begin
                int  old_sh[4];
                int  c, len;
                bit  pse;
                for (int i = 0; i < N; i++) old_sh[i] = m_sh[k][i];
                if (wr_en) m_sh[k][wr_ch] = (wr_duty > P) ? P : int'(wr_duty);
                e_oe[k] = oe_in;
                if (!run) begin
                    m_running[k] = 0; m_clks[k] = 0; m_pos[k] = 0;
                    e_out[k] = m_pol[k]; e_ps[k] = 1'b0;
                end else begin
                    c = cnt_of(m_mode[k], m_pos[k]);
                    for (int i = 0; i < N; i++)
                        e_out[k][i] = (chan_cnt(m_mode[k], c, i) < m_act[k][i]) ^ m_pol[k][i];
                    pse = !m_running[k];
                    if (m_clks[k] % m_presc[k] == m_presc[k] - 1) begin
                        len = m_mode[k] ? 2 * (P - 1) : P;
                        m_pos[k]++;
                        if (m_pos[k] == len) begin m_pos[k] = 0; pse = 1; end
                    end
                    m_clks[k]++;
                    if (pse) begin
                        for (int i = 0; i < N; i++) m_act[k][i] = old_sh[i];
                        m_mode[k] = center;
                    end
                    m_running[k] = 1;
                    e_ps[k] = pse;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            check("out_a", out_a, e_out[0]);
            check("oe_a",  oe_a,  e_oe[0]);
            check("ps_a",  ps_a,  e_ps[0]);
            check("out_b", out_b, e_out[1]);
            check("oe_b",  oe_b,  e_oe[1]);
            check("ps_b",  ps_b,  e_ps[1]);
        end
    end

    task automatic wr(input int ch, input int d);
        @(negedge clk);
        wr_en = 1'b1; wr_ch = 2'(ch); wr_duty = 4'(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_ps(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ps_a && n < 100);
        if (!ps_a) check("ps_timeout", 0, 1);
    endtask

    task automatic count_high(input int ch, input int cyc, output int n);
        n = 0;
        for (int c = 0; c < cyc; c++) begin
            @(negedge clk);
            n += int'(out_a[ch]);
        end
    endtask

    initial begin
        int         n;
        int         rise[4];
        logic [3:0] prev;

        repeat (3) @(negedge clk);
        check("rst_out_a", out_a, 4'b0000);
        check("rst_out_b", out_b, 4'b0101);
        check("rst_oe_a",  oe_a,  4'b0000);
        check("rst_ps_a",  ps_a,  1'b0);

        // Edge mode, default duty 5
        rst = 1'b0; run = 1'b1; oe_in = 4'b1010;
        wait_ps(n);
        check("t1_restart_ps", n, 1);
        wait_ps(n);
        wait_ps(n);
        check("t1_period", n, 10);
        count_high(0, 10, n);
        check("t1_ch0_high", n, 5);
        check("t1_oe", oe_a, 4'b1010);

        // Mid-period duty change applies from the next period
        repeat (3) @(negedge clk);
        wr(2, 3);
        wait_ps(n);
        count_high(2, 10, n);
        check("t2_ch2_high", n, 3);

        // Duty boundaries: 0, PERIOD, clamped
        wr(1, 0);  wait_ps(n); wait_ps(n);
        count_high(1, 20, n);
        check("t3_duty0", n, 0);
        wr(1, 10); wait_ps(n); wait_ps(n);
        count_high(1, 20, n);
        check("t3_duty10", n, 20);
        wr(1, 15); wait_ps(n); wait_ps(n);
        count_high(1, 20, n);
        check("t3_duty15", n, 20);

        // Channel edge spacing (staggered only when the option is built in)
        for (int i = 0; i < N; i++) wr(i, 5);
        wait_ps(n); wait_ps(n);
        prev = out_a;
        for (int i = 0; i < N; i++) rise[i] = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++)
                if (rise[i] < 0 && out_a[i] && !prev[i]) rise[i] = c;
            prev = out_a;
        end
        for (int i = 1; i < N; i++)
            check($sformatf("t6_rise_offset_ch%0d", i), (rise[0] - rise[i] + 20) % P, i * c_stride);

        // Center mode, duty 4; mode request only takes effect at a period start
        wr(0, 4);
        repeat (2) @(negedge clk);
        center = 1'b1;
        wait_ps(n);
        wait_ps(n);
        check("t4_center_period", n, 18);
        center = 1'b0;
        wait_ps(n);
        wait_ps(n);
        check("t4_edge_period", n, 10);

        // run low mid-period, then restart
        repeat (4) @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        check("t5_idle_out_a", out_a, 4'b0000);
        check("t5_idle_out_b", out_b, 4'b0101);
        check("t5_idle_ps", ps_a, 1'b0);
        oe_in = 4'b0110;
        @(negedge clk);
        check("t5_idle_oe", oe_a, 4'b0110);
        run = 1'b1;
        @(negedge clk);
        check("t5_restart_ps", ps_a, 1'b1);
        repeat (25) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
